// File: rtl/mem_cmd_sequencer_if.sv
// Bus bundle between the command sequencer, its host byte link and the Memory block.
// slave is the sequencer's view; master is the host/memory side.
interface mem_cmd_sequencer_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_error;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    modport slave (
        input  cmd_data, cmd_valid, rsp_ready, mem_rdata,
        output cmd_ready, rsp_data, rsp_valid, rsp_error, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cmd_data, cmd_valid, rsp_ready, mem_rdata,
        input  cmd_ready, rsp_data, rsp_valid, rsp_error, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// Decodes a byte-serial read/write command stream into single-port Memory accesses
// and returns exactly one response byte per command.
module mem_cmd_sequencer #(
    parameter int         MEM_DEPTH = 17,
    parameter logic [7:0] ERR_CODE  = 8'hEE
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_cmd_sequencer_if.slave bus,
    output logic               busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WDATA = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;
    localparam logic [2:0] RESP  = 3'd6;

    localparam logic [5:0] DEPTH = 6'(MEM_DEPTH);

    logic [2:0] state;
    logic [4:0] addr_q;
    logic       write_q;
    logic       legal_q;
    logic       cmd_xfer;
    logic       hdr_legal;
    logic       hdr_unused;

    // Ready depends only on state (and reset), never on cmd_valid.
    assign bus.cmd_ready = rst_n && (state == IDLE || state == WDATA);
    assign cmd_xfer      = bus.cmd_valid && bus.cmd_ready;
    assign hdr_legal     = {1'b0, bus.cmd_data[4:0]} < DEPTH;
    assign hdr_unused    = &bus.cmd_data[6:5];

    assign bus.mem_we = (state == WRITE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            write_q       <= 1'b0;
            legal_q       <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_error <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_xfer) begin
                    addr_q  <= bus.cmd_data[4:0];
                    write_q <= bus.cmd_data[7];
                    legal_q <= hdr_legal;
                    if (bus.cmd_data[7]) begin
                        state <= WDATA;
                    end else if (hdr_legal) begin
                        bus.mem_addr <= bus.cmd_data[4:0];
                        state        <= READ;
                    end else begin
                        state <= ERR;
                    end
                end
                // The data byte is consumed even for an illegal address.
                WDATA: if (cmd_xfer) begin
                    bus.mem_wdata <= bus.cmd_data;
                    if (legal_q && write_q) begin
                        bus.mem_addr <= addr_q;
                        state        <= WRITE;
                    end else begin
                        state <= ERR;
                    end
                end
                WRITE: state <= WAIT;
                READ:  state <= WAIT;
                // Memory output is registered: read data or echoed write data is ready here.
                WAIT: begin
                    bus.rsp_data  <= bus.mem_rdata;
                    bus.rsp_error <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                ERR: begin
                    bus.rsp_data  <= ERR_CODE;
                    bus.rsp_error <= 1'b1;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Scoreboard bench for mem_cmd_sequencer with a behavioural 32x8 registered-read memory.
module tb_mem_cmd_sequencer;
    localparam int         MEM_DEPTH = 17;
    localparam logic [7:0] ERR_CODE  = 8'hEE;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    mem_cmd_sequencer_if bus();

    mem_cmd_sequencer #(.MEM_DEPTH(MEM_DEPTH), .ERR_CODE(ERR_CODE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Memory block: write-first, registered output, not affected by reset.
    logic [7:0] mem [0:31] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_we === 1'b1) ? bus.mem_wdata : mem[bus.mem_addr];
    end

    logic [7:0] ref_mem [0:31] = '{default: 8'h00};
    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         e0       = 0;
    int         exp_we   = 0;
    int         we_count = 0;
    logic [4:0] we_addr  = '0;
    logic [7:0] we_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_count <= we_count + 1;
            we_addr  <= bus.mem_addr;
            we_data  <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {bus.cmd_ready, bus.rsp_valid, bus.rsp_error, bus.mem_we, busy,
                    bus.rsp_data, bus.mem_addr, bus.mem_wdata}, 32'd0);
    endtask

    // Offers one byte from a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 0;
        repeat (gap) @(negedge clk);
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                @(negedge clk);
                e0   = cyc;
                done = 1;
                break;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic get_rsp(input int hold, input bit poke);
        exp_t       e;
        logic [7:0] d;
        logic       er;
        int         n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", {31'd0, bus.rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("rsp_latency", cyc - e0 + 1, e.lat);
        check("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
        check("rsp_error", {31'd0, bus.rsp_error}, {31'd0, e.err});
        d  = bus.rsp_data;
        er = bus.rsp_error;
        if (poke) begin
            bus.cmd_data  = 8'h85;
            bus.cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", {bus.rsp_valid, bus.rsp_error, bus.rsp_data}, {1'b1, er, d});
            check("hold_ctrl", {bus.cmd_ready, busy}, {1'b0, 1'b1});
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_done_idle", {bus.rsp_valid, busy}, 2'b00);
    endtask

    task automatic do_cmd(input logic [7:0] hdr, input logic [7:0] wd,
                          input int gap, input int hold, input bit poke);
        exp_t       e;
        logic [4:0] a     = hdr[4:0];
        bit         legal = (int'(a) < MEM_DEPTH);
        e.err = !legal;
        e.lat = legal ? 3 : 2;
        if (hdr[7]) begin
            e.data = legal ? wd : ERR_CODE;
            if (legal) begin
                ref_mem[a] = wd;
                exp_we++;
            end
        end else begin
            e.data = legal ? ref_mem[a] : ERR_CODE;
        end
        sb.push_back(e);
        send_byte(hdr, gap);
        if (hdr[7]) send_byte(wd, gap);
        get_rsp(hold, poke);
        check("we_count", we_count, exp_we);
        if (hdr[7] && legal) check("we_addr_data", {we_addr, we_data}, {a, wd});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {bus.cmd_ready, busy}, 2'b10);

        do_cmd(8'h85, 8'h3C, 0, 0, 0);
        do_cmd(8'h05, 8'h00, 0, 0, 0);
        do_cmd(8'h90, 8'hA5, 1, 0, 0);
        do_cmd(8'h10, 8'h00, 0, 0, 0);
        do_cmd(8'h11, 8'h00, 0, 0, 0);
        do_cmd(8'h9F, 8'h55, 0, 0, 0);
        do_cmd(8'hF1, 8'h77, 2, 1, 0);
        do_cmd(8'h05, 8'h00, 0, 5, 1);

        // Abort a write in WDATA with reset; address 3 must keep its earlier value.
        do_cmd(8'h83, 8'h5A, 0, 0, 0);
        send_byte(8'h83, 0);
        check("in_wdata", {bus.cmd_ready, busy}, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_quiet", {bus.rsp_valid, busy, bus.mem_we}, 3'b000);
        end
        check("we_after_abort", we_count, exp_we);
        do_cmd(8'h03, 8'h00, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] h;
            logic [7:0] w;
            h = 8'($urandom);
            w = 8'($urandom);
            do_cmd(h, w, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
        end
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
